melody_sequencer: RTL and testbench

//  Autonomous tune player upstream of the beeper. Steps through a fixed note table and drives an
//  8-bit one-hot note code (bit0 = middle do ... bit7 = high do, 8'h00 = silence) plus a playing flag.

---
 rtl/melody_sequencer_pkg.sv | 51 +++++
 rtl/melody_rom.sv | 35 +++
 rtl/melody_sequencer.sv | 166 ++++++++++++++++
 tb/tb_melody_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/melody_sequencer_pkg.sv
// Shared types and constants for the melody sequencer: note codes, table entry layout, FSM states.
package melody_sequencer_pkg;

    localparam int unsigned CODE_W  = 4;
    localparam int unsigned DUR_W   = 2;
    localparam int unsigned ENTRY_W = CODE_W + DUR_W;
    localparam int unsigned NOTE_W  = 8;

    // Table note codes; 9..15 are illegal and play as rest
    localparam logic [CODE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [CODE_W-1:0] NOTE_DO   = 4'd1;
    localparam logic [CODE_W-1:0] NOTE_RE   = 4'd2;
    localparam logic [CODE_W-1:0] NOTE_MI   = 4'd3;
    localparam logic [CODE_W-1:0] NOTE_FA   = 4'd4;
    localparam logic [CODE_W-1:0] NOTE_SO   = 4'd5;
    localparam logic [CODE_W-1:0] NOTE_LA   = 4'd6;
    localparam logic [CODE_W-1:0] NOTE_TI   = 4'd7;
    localparam logic [CODE_W-1:0] NOTE_DO_H = 4'd8;

    // One table entry: note code plus duration (beats = dur + 1)
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [DUR_W-1:0]  dur;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Note code to one-hot beeper drive; rest and illegal codes are silent
    function automatic logic [NOTE_W-1:0] note_onehot(input logic [CODE_W-1:0] code);
        logic [NOTE_W-1:0] v;
        v = '0;
        case (code)
            NOTE_DO:   v = 8'h01;
            NOTE_RE:   v = 8'h02;
            NOTE_MI:   v = 8'h04;
            NOTE_FA:   v = 8'h08;
            NOTE_SO:   v = 8'h10;
            NOTE_LA:   v = 8'h20;
            NOTE_TI:   v = 8'h40;
            NOTE_DO_H: v = 8'h80;
            default:   v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Fixed tune table (Twinkle Twinkle): address -> note entry, purely combinational.
module melody_rom
    import melody_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] i_addr,
    output entry_t            o_entry_c
);

    // Table lookup; unlisted addresses are rests
    always_comb begin
        o_entry_c = '{code: NOTE_REST, dur: 2'd0};
        case (i_addr)
            ADDR_W'(0):  o_entry_c = '{code: NOTE_DO,   dur: 2'd0};
            ADDR_W'(1):  o_entry_c = '{code: NOTE_DO,   dur: 2'd0};
            ADDR_W'(2):  o_entry_c = '{code: NOTE_SO,   dur: 2'd0};
            ADDR_W'(3):  o_entry_c = '{code: NOTE_SO,   dur: 2'd0};
            ADDR_W'(4):  o_entry_c = '{code: NOTE_LA,   dur: 2'd0};
            ADDR_W'(5):  o_entry_c = '{code: NOTE_LA,   dur: 2'd0};
            ADDR_W'(6):  o_entry_c = '{code: NOTE_SO,   dur: 2'd1};
            ADDR_W'(7):  o_entry_c = '{code: NOTE_FA,   dur: 2'd0};
            ADDR_W'(8):  o_entry_c = '{code: NOTE_FA,   dur: 2'd0};
            ADDR_W'(9):  o_entry_c = '{code: NOTE_MI,   dur: 2'd0};
            ADDR_W'(10): o_entry_c = '{code: NOTE_MI,   dur: 2'd0};
            ADDR_W'(11): o_entry_c = '{code: NOTE_RE,   dur: 2'd0};
            ADDR_W'(12): o_entry_c = '{code: NOTE_RE,   dur: 2'd0};
            ADDR_W'(13): o_entry_c = '{code: NOTE_DO,   dur: 2'd1};
            ADDR_W'(14): o_entry_c = '{code: NOTE_REST, dur: 2'd0};
            ADDR_W'(15): o_entry_c = '{code: NOTE_REST, dur: 2'd0};
            default:     o_entry_c = '{code: NOTE_REST, dur: 2'd0};
        endcase
    end

endmodule

// File: rtl/melody_sequencer.sv
// Autonomous tune player: walks the note table, holds each note for 1-4 beats with a silent
// articulation gap at the end, and drives a one-hot note code to the beeper.
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_250_000,
    parameter int unsigned SONG_LEN    = 16,
    parameter int unsigned ADDR_W      = 4
) (
    input  logic              CLK_50M,
    input  logic              RST_N,
    input  logic              START,
    input  logic              STOP,
    input  logic              LOOP,
    output logic [NOTE_W-1:0] NOTE,
    output logic              PLAYING,
    output logic [ADDR_W-1:0] NOTE_IDX,
    output logic              SONG_END
);

    localparam int unsigned CYC_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [CYC_W-1:0]  CYC_LAST      = CYC_W'(BEAT_CYCLES - 1);
    localparam logic [CYC_W-1:0]  CYC_SOUND_END = CYC_W'(BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST     = ADDR_W'(SONG_LEN - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [CYC_W-1:0]    r_cyc;
    logic [CYC_W-1:0]    w_cyc_nxt;
    logic [DUR_W-1:0]    r_beat;
    logic [DUR_W-1:0]    w_beat_nxt;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   w_code_nxt;
    logic [DUR_W-1:0]    r_dur;
    logic [DUR_W-1:0]    w_dur_nxt;
    logic [NOTE_W-1:0]   r_note;
    logic [NOTE_W-1:0]   w_note_nxt;
    logic                r_playing;
    logic                w_playing_nxt;
    logic                r_song_end;
    logic                w_song_end_nxt;
    logic                w_cyc_last;
    entry_t              w_entry;

    melody_rom #(
        .ADDR_W (ADDR_W)
    ) u_rom (
        .i_addr    (r_addr),
        .o_entry_c (w_entry)
    );

    assign w_cyc_last = (r_cyc == CYC_LAST);

    // Next-state, counter and registered-output decode; outputs follow the state being entered
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_cyc_nxt      = r_cyc;
        w_beat_nxt     = r_beat;
        w_code_nxt     = r_code;
        w_dur_nxt      = r_dur;
        w_song_end_nxt = 1'b0;

        if (STOP) begin
            w_state_nxt = IDLE;
            w_addr_nxt  = '0;
            w_cyc_nxt   = '0;
            w_beat_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cyc_nxt  = '0;
                    w_beat_nxt = '0;
                    if (START) begin
                        w_state_nxt = FETCH;
                        w_addr_nxt  = '0;
                    end
                end
                FETCH: begin
                    w_code_nxt  = w_entry.code;
                    w_dur_nxt   = w_entry.dur;
                    w_cyc_nxt   = '0;
                    w_beat_nxt  = '0;
                    w_state_nxt = PLAY;
                end
                PLAY: begin
                    // The gap always starts before the beat wraps, so beat never passes dur
                    if (r_beat == r_dur && r_cyc == CYC_SOUND_END) begin
                        w_state_nxt = GAP;
                    end
                    if (w_cyc_last) begin
                        w_cyc_nxt  = '0;
                        w_beat_nxt = r_beat + DUR_W'(1);
                    end else begin
                        w_cyc_nxt  = r_cyc + CYC_W'(1);
                    end
                end
                GAP: begin
                    if (w_cyc_last) begin
                        w_cyc_nxt = '0;
                        if (r_addr < ADDR_LAST) begin
                            w_addr_nxt  = r_addr + ADDR_W'(1);
                            w_state_nxt = FETCH;
                        end else begin
                            w_song_end_nxt = 1'b1;
                            w_addr_nxt     = '0;
                            w_state_nxt    = LOOP ? FETCH : IDLE;
                        end
                    end else begin
                        w_cyc_nxt = r_cyc + CYC_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_addr_nxt  = '0;
                    w_cyc_nxt   = '0;
                    w_beat_nxt  = '0;
                end
            endcase
        end

        w_note_nxt    = (w_state_nxt == PLAY) ? note_onehot(w_code_nxt) : '0;
        w_playing_nxt = (w_state_nxt != IDLE);
    end

    // State register
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Address, counters, latched entry and output registers
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_addr     <= '0;
            r_cyc      <= '0;
            r_beat     <= '0;
            r_code     <= '0;
            r_dur      <= '0;
            r_note     <= '0;
            r_playing  <= 1'b0;
            r_song_end <= 1'b0;
        end else begin
            r_addr     <= w_addr_nxt;
            r_cyc      <= w_cyc_nxt;
            r_beat     <= w_beat_nxt;
            r_code     <= w_code_nxt;
            r_dur      <= w_dur_nxt;
            r_note     <= w_note_nxt;
            r_playing  <= w_playing_nxt;
            r_song_end <= w_song_end_nxt;
        end
    end

    assign NOTE     = r_note;
    assign PLAYING  = r_playing;
    assign NOTE_IDX = r_addr;
    assign SONG_END = r_song_end;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer with a shortened beat (10 cycles, 2-cycle gap).
module tb_melody_sequencer;

    localparam int unsigned BEAT = 10;
    localparam int unsigned GAPC = 2;

    typedef struct packed {
        logic [7:0] note;
        logic       playing;
        logic [3:0] idx;
        logic       se;
    } exp_t;

    logic       CLK_50M;
    logic       RST_N;
    logic       START;
    logic       STOP;
    logic       LOOP;
    logic [7:0] NOTE;
    logic       PLAYING;
    logic [3:0] NOTE_IDX;
    logic       SONG_END;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   cyc_no;
    int   se_cnt;
    int   se_cyc;

    // Reference tune: note code and duration field per entry
    int codes [16] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1, 0, 0};
    int durs  [16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    melody_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAPC),
        .SONG_LEN    (16),
        .ADDR_W      (4)
    ) dut (
        .CLK_50M  (CLK_50M),
        .RST_N    (RST_N),
        .START    (START),
        .STOP     (STOP),
        .LOOP     (LOOP),
        .NOTE     (NOTE),
        .PLAYING  (PLAYING),
        .NOTE_IDX (NOTE_IDX),
        .SONG_END (SONG_END)
    );

    initial CLK_50M = 1'b0;
    always #10 CLK_50M = ~CLK_50M;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc_no, got, exp);
        end
    endtask

    function automatic logic [7:0] tb_onehot(input int c);
        logic [7:0] one;
        one = 8'd1;
        if (c >= 1 && c <= 8) return one << (c - 1);
        return 8'h00;
    endfunction

    function automatic exp_t mk(input logic [7:0] note, input logic pl, input int idx, input logic se);
        exp_t e;
        e.note    = note;
        e.playing = pl;
        e.idx     = 4'(idx);
        e.se      = se;
        return e;
    endfunction

    // Fetch cycle, then ns sounding cycles, then ng gap cycles of entry i
    task automatic push_partial(input int i, input int ns, input int ng, input logic se);
        exp_q.push_back(mk(8'h00, 1'b1, i, se));
        for (int k = 0; k < ns; k++) exp_q.push_back(mk(tb_onehot(codes[i]), 1'b1, i, 1'b0));
        for (int k = 0; k < ng; k++) exp_q.push_back(mk(8'h00, 1'b1, i, 1'b0));
    endtask

    task automatic push_entry(input int i, input logic se);
        push_partial(i, (durs[i] + 1) * int'(BEAT) - int'(GAPC), int'(GAPC), se);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(mk(8'h00, 1'b0, 0, 1'b0));
    endtask

    // Advance one clock, sample 1 time unit after the edge, compare against the scoreboard head
    task automatic tick();
        exp_t e;
        @(posedge CLK_50M);
        #1;
        cyc_no++;
        if (SONG_END === 1'b1) begin
            se_cnt++;
            se_cyc = cyc_no;
        end
        if (exp_q.size() == 0) begin
            chk_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk_val("note",     32'(NOTE),     32'(e.note));
            chk_val("playing",  32'(PLAYING),  32'(e.playing));
            chk_val("note_idx", 32'(NOTE_IDX), 32'(e.idx));
            chk_val("song_end", 32'(SONG_END), 32'(e.se));
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) tick();
    endtask

    task automatic chk_all_reset(input string tag);
        chk_val({tag, "_note"},     32'(NOTE),     32'h00);
        chk_val({tag, "_playing"},  32'(PLAYING),  32'd0);
        chk_val({tag, "_idx"},      32'(NOTE_IDX), 32'd0);
        chk_val({tag, "_song_end"}, 32'(SONG_END), 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fetch_cyc;
        n_vec  = 0;
        n_err  = 0;
        cyc_no = 0;
        se_cnt = 0;
        se_cyc = 0;
        RST_N  = 1'b1;
        START  = 1'b0;
        STOP   = 1'b0;
        LOOP   = 1'b0;

        // Reset values
        #2 RST_N = 1'b0;
        @(posedge CLK_50M);
        @(posedge CLK_50M);
        #1;
        chk_all_reset("rst");
        RST_N = 1'b1;
        push_idle(3);
        drain();

        // Full song without looping: one SONG_END, 196 cycles after first FETCH, then idle
        START = 1'b1;
        for (int i = 0; i < 16; i++) push_entry(i, 1'b0);
        exp_q.push_back(mk(8'h00, 1'b0, 0, 1'b1));
        push_idle(3);
        tick();
        START = 1'b0;
        fetch_cyc = cyc_no;
        se_cnt = 0;
        drain();
        chk_val("song_end_count", 32'(se_cnt), 32'd1);
        chk_val("song_end_delay", 32'(se_cyc - fetch_cyc), 32'd196);

        // Looping song: wraps to entry 0 while still playing, then STOP mid-PLAY of entry 3
        LOOP   = 1'b1;
        se_cnt = 0;
        START  = 1'b1;
        for (int i = 0; i < 16; i++) push_entry(i, 1'b0);
        push_entry(0, 1'b1);
        push_entry(1, 1'b0);
        push_entry(2, 1'b0);
        push_partial(3, 4, 0, 1'b0);
        tick();
        START = 1'b0;
        drain();
        chk_val("loop_song_end_count", 32'(se_cnt), 32'd1);
        STOP = 1'b1;
        push_idle(1);
        tick();
        STOP = 1'b0;
        LOOP = 1'b0;
        push_idle(3);
        drain();

        // START and STOP together while idle: STOP wins
        START = 1'b1;
        STOP  = 1'b1;
        push_idle(1);
        tick();
        START = 1'b0;
        STOP  = 1'b0;
        push_idle(2);
        drain();

        // START during playback is ignored; stop inside entry 1's gap by reset
        START = 1'b1;
        push_entry(0, 1'b0);
        push_partial(1, 8, 1, 1'b0);
        tick();
        START = 1'b0;
        for (int k = 0; exp_q.size() > 0; k++) begin
            START = (k == 4) ? 1'b1 : 1'b0;
            tick();
        end
        START = 1'b0;
        RST_N = 1'b0;
        #2;
        chk_all_reset("async_gap");
        @(posedge CLK_50M);
        @(posedge CLK_50M);
        #1;
        RST_N = 1'b1;
        push_idle(5);
        drain();

        // Reset while a note is sounding drops NOTE immediately
        START = 1'b1;
        push_partial(0, 3, 0, 1'b0);
        tick();
        START = 1'b0;
        drain();
        chk_val("pre_rst_note", 32'(NOTE), 32'h01);
        RST_N = 1'b0;
        #2;
        chk_all_reset("async_play");
        @(posedge CLK_50M);
        #1;
        RST_N = 1'b1;
        push_idle(3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
